pixel_recover_sync: RTL and testbench

//  Parametrised camera-pixel recovery front end in the system clock domain.

---
 rtl/pixel_recover_pkg.sv | 19 +
 rtl/sync_rise_det.sv | 35 +++
 rtl/pixel_recover_sync.sv | 188 ++++++++++++++++++
 tb/tb_pixel_recover_sync.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_recover_pkg.sv
// Shared types and default geometry for the camera pixel recovery front end.
// Optional build macro: PIXEL_RECOVER_STATS_EN (frame/drop statistics counters).
package pixel_recover_pkg;

   // Capture state: idle until the first frame marker, capturing, or frame complete.
   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACTIVE     = 2'd1,
      FULL       = 2'd2
   } recover_state_t;

   localparam int PIXEL_W_DEF     = 7;
   localparam int H_ACTIVE_DEF    = 320;
   localparam int V_ACTIVE_DEF    = 240;
   localparam int SYNC_STAGES_DEF = 2;

   localparam int STAT_W = 16;

endpackage

// File: rtl/sync_rise_det.sv
// N-flop synchroniser for an asynchronous level, followed by a one-clock
// rising-edge pulse generated from the synchronised level.
module sync_rise_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_out
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Shift the raw input through the synchroniser and remember the last settled level.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      prev_d = sync_q[STAGES-1];
   end

   // Synchroniser and edge-history flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_out = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pixel_recover_sync.sv
// Camera pixel recovery front end: synchronises the camera strobe and
// end-of-frame marker, captures one pixel per strobe edge and tags it with
// its (hcount, vcount) position plus frame/line markers and error flags.
// Optional build macro: PIXEL_RECOVER_STATS_EN adds frame_count_out and
// drop_count_out; without it those ports and counters do not exist.
module pixel_recover_sync
   import pixel_recover_pkg::*;
#(
   parameter int PIXEL_W     = PIXEL_W_DEF,
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                        system_clk_in,
   input  logic                        rst_in,
   input  logic                        valid_pixel_in,
   input  logic [PIXEL_W-1:0]          pixel_in,
   input  logic                        frame_done_in,
   output logic [PIXEL_W-1:0]          pixel_out,
   output logic                        data_valid_out,
   output logic [$clog2(H_ACTIVE)-1:0] hcount_out,
   output logic [$clog2(V_ACTIVE)-1:0] vcount_out,
   output logic                        frame_start_out,
   output logic                        line_end_out,
   output logic                        overflow_out,
   output logic                        short_frame_out
`ifdef PIXEL_RECOVER_STATS_EN
   ,
   output logic [STAT_W-1:0]           frame_count_out,
   output logic [STAT_W-1:0]           drop_count_out
`endif
);

   localparam int HW = $clog2(H_ACTIVE);
   localparam int VW = $clog2(V_ACTIVE);
   localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

   logic pix_rise;
   logic fd_rise;

   sync_rise_det #(.STAGES(SYNC_STAGES)) u_valid_sync (
      .clk      (system_clk_in),
      .rst_n    (rst_in),
      .async_in (valid_pixel_in),
      .rise_out (pix_rise)
   );

   sync_rise_det #(.STAGES(SYNC_STAGES)) u_frame_done_sync (
      .clk      (system_clk_in),
      .rst_n    (rst_in),
      .async_in (frame_done_in),
      .rise_out (fd_rise)
   );

   recover_state_t     state_q, state_d;
   logic [HW-1:0]      h_q, h_d;
   logic [VW-1:0]      v_q, v_d;
   logic [PIXEL_W-1:0] pixel_q, pixel_d;
   logic [HW-1:0]      hout_q, hout_d;
   logic [VW-1:0]      vout_q, vout_d;
   logic               dv_q, dv_d;
   logic               fs_q, fs_d;
   logic               le_q, le_d;
   logic               ovf_q, ovf_d;
   logic               short_q, short_d;
`ifdef PIXEL_RECOVER_STATS_EN
   logic [STAT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [STAT_W-1:0]  drop_cnt_q, drop_cnt_d;
`endif

   // Next-state for the capture FSM, position counters and all registered outputs.
   // NOTE: every signal gets a default at the top so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      pixel_d = pixel_q;
      hout_d  = hout_q;
      vout_d  = vout_q;
      dv_d    = 1'b0;
      fs_d    = 1'b0;
      le_d    = 1'b0;
      ovf_d   = ovf_q;
      short_d = 1'b0;
`ifdef PIXEL_RECOVER_STATS_EN
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
`endif

      if (fd_rise) begin
         // Frame marker wins over a coincident pixel edge; that pixel is lost.
         short_d = (state_q == ACTIVE) && ((h_q != '0) || (v_q != '0));
         state_d = ACTIVE;
         h_d     = '0;
         v_d     = '0;
         ovf_d   = 1'b0;
`ifdef PIXEL_RECOVER_STATS_EN
         if (state_q != WAIT_FRAME) begin
            frame_cnt_d = frame_cnt_q + STAT_W'(1);
         end
         drop_cnt_d = (pix_rise && (state_q != WAIT_FRAME)) ? STAT_W'(1) : '0;
`endif
      end else if (pix_rise) begin
         unique case (state_q)
            ACTIVE: begin
               dv_d    = 1'b1;
               pixel_d = pixel_in;
               hout_d  = h_q;
               vout_d  = v_q;
               fs_d    = (h_q == '0) && (v_q == '0);
               le_d    = (h_q == H_LAST);
               if (h_q == H_LAST) begin
                  if (v_q == V_LAST) begin
                     // Frame complete: counters park on the last position.
                     state_d = FULL;
                  end else begin
                     h_d = '0;
                     v_d = v_q + VW'(1);
                  end
               end else begin
                  h_d = h_q + HW'(1);
               end
            end
            FULL: begin
               ovf_d = 1'b1;
`ifdef PIXEL_RECOVER_STATS_EN
               if (drop_cnt_q != {STAT_W{1'b1}}) begin
                  drop_cnt_d = drop_cnt_q + STAT_W'(1);
               end
`endif
            end
            default: ; // WAIT_FRAME: pixels before the first frame marker are ignored
         endcase
      end
   end

   // State, counter and output registers; reset returns to WAIT_FRAME with everything cleared.
   always_ff @(posedge system_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= WAIT_FRAME;
         h_q     <= '0;
         v_q     <= '0;
         pixel_q <= '0;
         hout_q  <= '0;
         vout_q  <= '0;
         dv_q    <= 1'b0;
         fs_q    <= 1'b0;
         le_q    <= 1'b0;
         ovf_q   <= 1'b0;
         short_q <= 1'b0;
`ifdef PIXEL_RECOVER_STATS_EN
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pixel_q <= pixel_d;
         hout_q  <= hout_d;
         vout_q  <= vout_d;
         dv_q    <= dv_d;
         fs_q    <= fs_d;
         le_q    <= le_d;
         ovf_q   <= ovf_d;
         short_q <= short_d;
`ifdef PIXEL_RECOVER_STATS_EN
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
`endif
      end
   end

   assign pixel_out       = pixel_q;
   assign data_valid_out  = dv_q;
   assign hcount_out      = hout_q;
   assign vcount_out      = vout_q;
   assign frame_start_out = fs_q;
   assign line_end_out    = le_q;
   assign overflow_out    = ovf_q;
   assign short_frame_out = short_q;
`ifdef PIXEL_RECOVER_STATS_EN
   assign frame_count_out = frame_cnt_q;
   assign drop_count_out  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_recover_sync.sv
// Randomised self-checking bench for pixel_recover_sync (4x3 frame, 2 sync stages).
// A frame-level model (pixel index n -> (n%4, n/4)) predicts every output cycle.
module tb_pixel_recover_sync;

   localparam int PW  = 7;
   localparam int HA  = 4;
   localparam int VA  = 3;
   localparam int SS  = 2;
   localparam int LAT = SS + 1;

   logic          clk = 1'b0;
   logic          rst_in = 1'b0;
   logic          valid_pixel_in = 1'b0;
   logic [PW-1:0] pixel_in = '0;
   logic          frame_done_in = 1'b0;
   logic [PW-1:0] pixel_out;
   logic          data_valid_out;
   logic [1:0]    hcount_out;
   logic [1:0]    vcount_out;
   logic          frame_start_out, line_end_out, overflow_out, short_frame_out;
`ifdef PIXEL_RECOVER_STATS_EN
   logic [15:0]   frame_count_out, drop_count_out;
`endif

   pixel_recover_sync #(.PIXEL_W(PW), .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_STAGES(SS)) dut (
      .system_clk_in   (clk),
      .rst_in          (rst_in),
      .valid_pixel_in  (valid_pixel_in),
      .pixel_in        (pixel_in),
      .frame_done_in   (frame_done_in),
      .pixel_out       (pixel_out),
      .data_valid_out  (data_valid_out),
      .hcount_out      (hcount_out),
      .vcount_out      (vcount_out),
      .frame_start_out (frame_start_out),
      .line_end_out    (line_end_out),
      .overflow_out    (overflow_out),
      .short_frame_out (short_frame_out)
`ifdef PIXEL_RECOVER_STATS_EN
      ,
      .frame_count_out (frame_count_out),
      .drop_count_out  (drop_count_out)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_WAIT, M_RUN, M_FULL} mode_t;
   typedef struct packed {
      logic          dv;
      logic [PW-1:0] pix;
      logic [1:0]    h;
      logic [1:0]    v;
      logic          fs;
      logic          le;
      logic          ovf_set;
      logic          ovf_clr;
      logic          shrt;
   } ev_t;

   mode_t mode = M_WAIT;
   int    n    = 0;          // pixels accepted in the current frame
   ev_t   sched [int];       // expected effects keyed by the cycle they become visible

   // Expected output registers
   logic [PW-1:0] exp_pix = '0;
   logic [1:0]    exp_h = '0, exp_v = '0;
   logic          exp_dv = 0, exp_fs = 0, exp_le = 0, exp_ovf = 0, exp_short = 0;

   // Called at the moment the bench raises a strobe (and/or frame marker).
   task automatic model_apply(input logic pr, input logic fr, input logic [PW-1:0] p);
      ev_t e;
      e = '0;
      if (fr) begin
         e.shrt    = (mode == M_RUN) && (n > 0);
         e.ovf_clr = 1'b1;
         mode      = M_RUN;
         n         = 0;
      end else if (pr) begin
         if (mode == M_RUN) begin
            e.dv  = 1'b1;
            e.pix = p;
            e.h   = 2'(n % HA);
            e.v   = 2'(n / HA);
            e.fs  = (n == 0);
            e.le  = ((n % HA) == HA - 1);
            n++;
            if (n == HA * VA) mode = M_FULL;
         end else if (mode == M_FULL) begin
            e.ovf_set = 1'b1;
         end
      end
      sched[cyc + LAT] = e;
   endtask

   task automatic model_reset();
      sched.delete();
      mode = M_WAIT; n = 0;
      exp_pix = '0; exp_h = '0; exp_v = '0;
      exp_dv = 0; exp_fs = 0; exp_le = 0; exp_ovf = 0; exp_short = 0;
   endtask

   // Observations kept for the literal checks
   typedef struct {logic [PW-1:0] pix; int h; int v; logic fs; logic le; int c;} obs_t;
   obs_t got_q[$];
   int   short_seen = 0;

   // One comparison per cycle of the full output bundle against the model.
   always @(negedge clk) begin
      if (rst_in) begin
         ev_t e;
         logic [15:0] got_v, exp_v_all;
         exp_dv = 0; exp_fs = 0; exp_le = 0; exp_short = 0;
         if (sched.exists(cyc)) begin
            e = sched[cyc];
            sched.delete(cyc);
            exp_dv = e.dv; exp_fs = e.fs; exp_le = e.le; exp_short = e.shrt;
            if (e.dv) begin
               exp_pix = e.pix; exp_h = e.h; exp_v = e.v;
            end
            if (e.ovf_set) exp_ovf = 1'b1;
            if (e.ovf_clr) exp_ovf = 1'b0;
         end
         got_v     = {data_valid_out, pixel_out, exp_dv ? hcount_out : 2'b0, exp_dv ? vcount_out : 2'b0,
                      frame_start_out, line_end_out, overflow_out, short_frame_out};
         exp_v_all = {exp_dv, exp_pix, exp_dv ? exp_h : 2'b0, exp_dv ? exp_v : 2'b0,
                      exp_fs, exp_le, exp_ovf, exp_short};
         check("outputs{dv,pix,h,v,fs,le,ovf,short}", 64'(got_v), 64'(exp_v_all));
         if (data_valid_out)
            got_q.push_back('{pix: pixel_out, h: int'(hcount_out), v: int'(vcount_out),
                              fs: frame_start_out, le: line_end_out, c: cyc});
         if (short_frame_out) short_seen++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_pix(input logic [PW-1:0] p, output int raise_cyc);
      @(negedge clk);
      pixel_in = p;
      valid_pixel_in = 1'b1;
      raise_cyc = cyc;
      model_apply(1'b1, 1'b0, p);
      repeat (2) @(negedge clk);
      valid_pixel_in = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic pulse_fd(input logic with_pix, input logic [PW-1:0] p);
      @(negedge clk);
      frame_done_in = 1'b1;
      if (with_pix) begin
         pixel_in = p;
         valid_pixel_in = 1'b1;
      end
      model_apply(with_pix, 1'b1, p);
      repeat (2) @(negedge clk);
      frame_done_in = 1'b0;
      valid_pixel_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic settle();
      repeat (LAT + 2) @(negedge clk);
   endtask

   int rc, rc0, base_short;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outputs", {pixel_out, data_valid_out, overflow_out, short_frame_out},
            {7'd0, 1'b0, 1'b0, 1'b0});
      rst_in = 1'b1;

      // 1. strobes with no frame marker are ignored
      for (int k = 0; k < 3; k++) pulse_pix(PW'(k + 40), rc);
      settle();
      check("no_output_before_frame_done", got_q.size(), 0);

      // 2. one full frame, pixel = k
      pulse_fd(1'b0, '0);
      got_q.delete();
      for (int k = 0; k < HA * VA; k++) begin
         pulse_pix(PW'(k), rc);
         if (k == 0) rc0 = rc;
      end
      settle();
      check("full_frame_count", got_q.size(), 12);
      if (got_q.size() == 12) begin
         check("lat_first_pixel", got_q[0].c - rc0, 3);
         check("px0_fs_pos", {got_q[0].fs, 2'(got_q[0].h), 2'(got_q[0].v)}, {1'b1, 2'd0, 2'd0});
         check("px3_le_pos", {got_q[3].le, 2'(got_q[3].h), 2'(got_q[3].v)}, {1'b1, 2'd3, 2'd0});
         check("px7_le_pos", {got_q[7].le, 2'(got_q[7].h), 2'(got_q[7].v)}, {1'b1, 2'd3, 2'd1});
         check("px9_pos", {got_q[9].le, got_q[9].pix, 2'(got_q[9].h), 2'(got_q[9].v)},
               {1'b0, 7'd9, 2'd1, 2'd2});
         check("px11_last", {got_q[11].le, 2'(got_q[11].h), 2'(got_q[11].v)}, {1'b1, 2'd3, 2'd2});
      end

      // 3. overflow after a full frame, cleared by frame_done without a short pulse
      got_q.delete();
      base_short = short_seen;
      pulse_pix(7'd100, rc);
      pulse_pix(7'd101, rc);
      settle();
      check("no_output_when_full", got_q.size(), 0);
      check("overflow_set", overflow_out, 1'b1);
      pulse_fd(1'b0, '0);
      settle();
      check("overflow_cleared", overflow_out, 1'b0);
      check("no_short_after_full", short_seen - base_short, 0);

      // 4. short frame
      for (int k = 0; k < 5; k++) pulse_pix(PW'(20 + k), rc);
      base_short = short_seen;
      pulse_fd(1'b0, '0);
      got_q.delete();
      pulse_pix(7'd55, rc);
      settle();
      check("short_pulse_once", short_seen - base_short, 1);
      check("restart_at_origin", {got_q.size() == 1, 2'(hcount_out), 2'(vcount_out)},
            {1'b1, 2'd0, 2'd0});

      // 5. collision: frame_done wins, pixel dropped
      got_q.delete();
      pulse_fd(1'b1, 7'd77);
      settle();
      check("collision_dropped", got_q.size(), 0);
`ifdef PIXEL_RECOVER_STATS_EN
      check("collision_drop_count", drop_count_out, 16'd1);
`endif

      // 6. reset mid-line at (2,1)
      pulse_fd(1'b0, '0);
      for (int k = 0; k < 7; k++) pulse_pix(PW'(60 + k), rc);
      settle();
      check("pre_reset_pos", {2'(hcount_out), 2'(vcount_out)}, {2'd2, 2'd1});
      @(negedge clk);
      #2 rst_in = 1'b0;
      model_reset();
      #1 check("async_reset_clears", {pixel_out, hcount_out, vcount_out, data_valid_out, overflow_out},
               {7'd0, 2'd0, 2'd0, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      rst_in = 1'b1;
      got_q.delete();
      pulse_pix(7'd11, rc);
      pulse_pix(7'd12, rc);
      settle();
      check("ignored_after_reset", got_q.size(), 0);
      pulse_fd(1'b0, '0);
      pulse_pix(7'd99, rc);
      settle();
      check("restart_after_reset", {got_q.size() == 1, pixel_out, 2'(hcount_out), 2'(vcount_out)},
            {1'b1, 7'd99, 2'd0, 2'd0});

      // Randomised frames of random length with occasional collisions
      for (int f = 0; f < 8; f++) begin
         int len;
         pulse_fd(1'b0, '0);
         len = $urandom_range(0, 15);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) pulse_fd(1'b1, PW'($urandom));
            else pulse_pix(PW'($urandom), rc);
         end
      end
      pulse_fd(1'b0, '0);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
